fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 ImemReq  output  1  instruction-memory request valid.
REQ-005 ImemAddr  output  32  word-aligned fetch address; bits[1:0] always 2'b00.
REQ-006 ImemAck  input  1  request accepted this cycle; transfer occurs when ImemReq & ImemAck.
REQ-007 ImemRValid  input  1  read data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-008 ImemRData  input  32  instruction word returned.
REQ-009 Redirect  input  1  PC redirect, from taken branch or write to R15 (PCS qualified by condition).
REQ-010 RedirectPC  input  32  redirect target; bits[1:0] ignored and treated as 2'b00.
REQ-011 DecReady  input  1  decoder accepts the head instruction this cycle.
REQ-012 InstrValid  output  1  Instr and InstrPC hold a valid instruction.
REQ-013 Instr  output  32  instruction word to the decoder (Op, Funct, Rd fields).
REQ-014 InstrPC  output  32  address of Instr.

Function
REQ-015 The block SHALL hold a fetch PC register and a 2-entry instruction FIFO of {Instr, InstrPC}; outputs SHALL come from registered FIFO state only.
REQ-016 Credit rule: ImemReq SHALL be 1 only when in-flight requests + FIFO occupancy + pending discards < 2 and Redirect = 0.
REQ-017 On ImemReq & ImemAck, the fetch PC SHALL advance by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-018 ImemAddr SHALL equal the fetch PC and SHALL stay stable while ImemReq & !ImemAck.
REQ-019 ImemRValid SHALL write {ImemRData, address of that request} into the FIFO tail; InstrValid SHALL rise in the cycle after ImemRValid (1-cycle latency).
REQ-020 InstrValid SHALL be 1 whenever the FIFO is non-empty; the head SHALL pop when InstrValid & DecReady.
REQ-021 A simultaneous push and pop SHALL preserve order and occupancy; push into a full FIFO cannot occur under REQ-016.
REQ-022 Redirect = 1 SHALL force ImemReq = 0 that cycle, empty the FIFO at the next edge, load the fetch PC with {RedirectPC[31:2],2'b00}, and move all in-flight requests to the discard count.
REQ-023 Redirect has priority over a same-cycle pop or push; the popped or pushed instruction SHALL be dropped.
REQ-024 Each ImemRValid SHALL first decrement a nonzero discard count without writing the FIFO.
REQ-025 Redirect while requests are still being discarded SHALL add the new in-flight requests to the discard count; the count saturates at 2 by construction.
REQ-026 DecReady = 0 SHALL stall the outputs unchanged; fetch stops when the credits of REQ-016 are used up.
REQ-027 A redirect that occurs while stalled SHALL still flush the FIFO.

Reset
REQ-028 While reset = 0: ImemReq = 0, ImemAddr = RESET_PC, InstrValid = 0, Instr = 0, InstrPC = 0, FIFO empty, in-flight and discard counts = 0.
REQ-029 ImemReq SHALL assert in the first cycle after reset deasserts, with ImemAddr = RESET_PC.
REQ-030 Reset asserted mid-operation SHALL abandon all in-flight requests; the memory side is reset by the same signal.

Configuration
REQ-031 Macro FETCH_PCPLUS8_EN: when defined, an extra output PCPlus8 (32) SHALL equal InstrPC + 8, registered with the FIFO entry and reset to 0.
REQ-032 When FETCH_PCPLUS8_EN is undefined, the PCPlus8 port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Reset release, memory always acks and returns data 1 cycle later, DecReady = 1 -> ImemAddr 0x0, 0x4, 0x8 on consecutive cycles; InstrValid first asserts 2 cycles after the first ack, with InstrPC = 0x0.
REQ-034 DecReady held 0 -> exactly 2 accepted requests, then ImemReq = 0; Instr and InstrPC stay at the 0x0 entry; on DecReady = 1, entries 0x0 and 0x4 pop in order.
REQ-035 Redirect to 0x100 with 2 requests in flight -> both responses discarded, next ImemAddr = 0x100, and no instruction from 0x8 or 0xC reaches InstrValid.
REQ-036 Redirect in the same cycle as a pop and a response -> FIFO empty next cycle, InstrValid = 0, next fetch from the target.
REQ-037 RedirectPC = 0xFFFF_FFFE -> ImemAddr = 0xFFFF_FFFC, then 0x0000_0000 after the wrap.
REQ-038 Reset pulled low with 1 request in flight and the FIFO full -> all outputs at reset values immediately; after release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited fetch PC and 2-entry {Instr, InstrPC} FIFO.
// Optional macro FETCH_PCPLUS8_EN adds a registered PCPlus8 output.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemAck,
   input  logic        ImemRValid,
   input  logic [31:0] ImemRData,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   input  logic        DecReady,
   output logic        InstrValid,
   output logic [31:0] Instr,
`ifdef FETCH_PCPLUS8_EN
   output logic [31:0] PCPlus8,
`endif
   output logic [31:0] InstrPC
);

   logic [31:0] r_pc;
   logic [1:0]  r_inflight;
   logic [1:0]  r_discard;
   logic [1:0]  r_cnt;
   logic [31:0] r_instr0, r_instr1;
   logic [31:0] r_ipc0, r_ipc1;

   logic [31:0] w_pc_d;
   logic [1:0]  w_inflight_d;
   logic [1:0]  w_discard_d;
   logic [1:0]  w_cnt_d;
   logic [31:0] w_instr0_d, w_instr1_d;
   logic [31:0] w_ipc0_d, w_ipc1_d;

   logic [2:0]  w_credit;
   logic        w_req;
   logic        w_fire;
   logic        w_keep;
   logic        w_drop;
   logic        w_pop;
   logic [31:0] w_rsp_pc;
   logic        w_unused;

`ifdef FETCH_PCPLUS8_EN
   logic [31:0] r_p8_0, r_p8_1;
   logic [31:0] w_p8_0_d, w_p8_1_d;
`endif

   assign w_credit = {1'b0, r_inflight} + {1'b0, r_cnt} + {1'b0, r_discard};
   assign w_req    = reset & ~Redirect & (w_credit < 3'd2);
   assign w_fire   = w_req & ImemAck;
   assign w_drop   = ImemRValid & (r_discard != 2'd0);
   assign w_keep   = ImemRValid & (r_discard == 2'd0);
   assign w_pop    = (r_cnt != 2'd0) & DecReady;
   // Kept in-flight requests are consecutive words ending just below the fetch PC.
   assign w_rsp_pc = r_pc - {28'd0, r_inflight, 2'b00};
   assign w_unused = ^RedirectPC[1:0];

   assign ImemReq    = w_req;
   assign ImemAddr   = r_pc;
   assign InstrValid = (r_cnt != 2'd0);
   assign Instr      = r_instr0;
   assign InstrPC    = r_ipc0;
`ifdef FETCH_PCPLUS8_EN
   assign PCPlus8    = r_p8_0;
`endif

   always_comb begin
      w_pc_d       = r_pc;
      w_inflight_d = r_inflight;
      w_discard_d  = r_discard;
      w_cnt_d      = r_cnt;
      w_instr0_d   = r_instr0;
      w_instr1_d   = r_instr1;
      w_ipc0_d     = r_ipc0;
      w_ipc1_d     = r_ipc1;
`ifdef FETCH_PCPLUS8_EN
      w_p8_0_d     = r_p8_0;
      w_p8_1_d     = r_p8_1;
`endif
      if (Redirect) begin
         w_pc_d       = {RedirectPC[31:2], 2'b00};
         w_inflight_d = 2'd0;
         // A same-cycle response retires either a discard or a (now dropped) in-flight request.
         w_discard_d  = r_discard + r_inflight - {1'b0, ImemRValid};
         w_cnt_d      = 2'd0;
      end else begin
         if (w_fire) begin
            w_pc_d = r_pc + 32'd4;
         end
         w_inflight_d = r_inflight + {1'b0, w_fire} - {1'b0, w_keep};
         if (w_drop) begin
            w_discard_d = r_discard - 2'd1;
         end
         case ({w_keep, w_pop})
            2'b11: begin
               if (r_cnt == 2'd1) begin
                  w_instr0_d = ImemRData;
                  w_ipc0_d   = w_rsp_pc;
`ifdef FETCH_PCPLUS8_EN
                  w_p8_0_d   = w_rsp_pc + 32'd8;
`endif
               end else begin
                  w_instr0_d = r_instr1;
                  w_ipc0_d   = r_ipc1;
                  w_instr1_d = ImemRData;
                  w_ipc1_d   = w_rsp_pc;
`ifdef FETCH_PCPLUS8_EN
                  w_p8_0_d   = r_p8_1;
                  w_p8_1_d   = w_rsp_pc + 32'd8;
`endif
               end
            end
            2'b01: begin
               w_instr0_d = r_instr1;
               w_ipc0_d   = r_ipc1;
`ifdef FETCH_PCPLUS8_EN
               w_p8_0_d   = r_p8_1;
`endif
               w_cnt_d    = r_cnt - 2'd1;
            end
            2'b10: begin
               if (r_cnt == 2'd0) begin
                  w_instr0_d = ImemRData;
                  w_ipc0_d   = w_rsp_pc;
`ifdef FETCH_PCPLUS8_EN
                  w_p8_0_d   = w_rsp_pc + 32'd8;
`endif
               end else begin
                  w_instr1_d = ImemRData;
                  w_ipc1_d   = w_rsp_pc;
`ifdef FETCH_PCPLUS8_EN
                  w_p8_1_d   = w_rsp_pc + 32'd8;
`endif
               end
               w_cnt_d = r_cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc       <= {RESET_PC[31:2], 2'b00};
         r_inflight <= 2'd0;
         r_discard  <= 2'd0;
         r_cnt      <= 2'd0;
         r_instr0   <= 32'd0;
         r_instr1   <= 32'd0;
         r_ipc0     <= 32'd0;
         r_ipc1     <= 32'd0;
`ifdef FETCH_PCPLUS8_EN
         r_p8_0     <= 32'd0;
         r_p8_1     <= 32'd0;
`endif
      end else begin
         r_pc       <= w_pc_d;
         r_inflight <= w_inflight_d;
         r_discard  <= w_discard_d;
         r_cnt      <= w_cnt_d;
         r_instr0   <= w_instr0_d;
         r_instr1   <= w_instr1_d;
         r_ipc0     <= w_ipc0_d;
         r_ipc1     <= w_ipc1_d;
`ifdef FETCH_PCPLUS8_EN
         r_p8_0     <= w_p8_0_d;
         r_p8_1     <= w_p8_1_d;
`endif
      end
   end

endmodule
